pipe_carry_adder: RTL and testbench

Parametrised, pipelined carry-propagate adder that splits a WIDTH-bit addition into SEG-bit ripple segments, one segment per pipeline stage, with the carry registered between stages. It is the wide-operand successor of the team's 8-bit ripple adder and serves the final partial-product summation of the wide Vedic multipliers, where a single-cycle 64-/128-bit ripple chain cannot meet timing. A valid/ready handshake on both sides lets the adder stall under back-pressure without losing or duplicating results.

---
 rtl/pipe_add_pkg.sv | 9 +
 rtl/pipe_carry_adder_if.sv | 28 ++
 rtl/pipe_add_seg.sv | 24 ++
 rtl/pipe_carry_adder.sv | 99 +++++++++
 tb/tb_pipe_carry_adder.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_add_pkg.sv
// pipe_add_pkg: shared defaults and configuration check for the pipelined carry adder.
package pipe_add_pkg;
   localparam int PIPE_ADD_WIDTH = 64;
   localparam int PIPE_ADD_SEG   = 8;
   function automatic bit seg_fits(input int width, input int seg);
      return seg > 0 && width >= seg && width % seg == 0;
   endfunction
   localparam bit PIPE_ADD_CFG_OK = seg_fits(PIPE_ADD_WIDTH, PIPE_ADD_SEG);
endpackage

// File: rtl/pipe_carry_adder_if.sv
// pipe_carry_adder_if: operand/result handshake bundle; PIPE_ADD_SUB_EN adds in_sub.
interface pipe_carry_adder_if
   import pipe_add_pkg::*;
#(
   parameter int WIDTH = PIPE_ADD_WIDTH
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
`ifdef PIPE_ADD_SUB_EN
   logic             in_sub;
   modport master (output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                   input  in_ready, out_valid, out_sum, out_cout);
   modport slave  (input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                   output in_ready, out_valid, out_sum, out_cout);
`else
   modport master (output in_valid, in_a, in_b, in_cin, out_ready,
                   input  in_ready, out_valid, out_sum, out_cout);
   modport slave  (input  in_valid, in_a, in_b, in_cin, out_ready,
                   output in_ready, out_valid, out_sum, out_cout);
`endif
endinterface

// File: rtl/pipe_add_seg.sv
// pipe_add_seg: combinational SEG-bit ripple-carry segment adder.
module pipe_add_seg
   import pipe_add_pkg::*;
#(
   parameter int SEG = PIPE_ADD_SEG
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout
);
   logic [SEG:0] c;
   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < SEG; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[SEG];
   end
endmodule

// File: rtl/pipe_carry_adder.sv
// pipe_carry_adder: WIDTH-bit adder pipelined as SEG-bit ripple stages with valid/ready flow control.
// Define PIPE_ADD_SUB_EN to add the in_sub (A - B) mode.
module pipe_carry_adder
   import pipe_add_pkg::*;
#(
   parameter int WIDTH = PIPE_ADD_WIDTH,
   parameter int SEG   = PIPE_ADD_SEG
) (
   input logic               clk,
   input logic               rst_n,
   pipe_carry_adder_if.slave bus
);
   localparam int NSEG = WIDTH / SEG;
   if (!PIPE_ADD_CFG_OK || !seg_fits(WIDTH, SEG)) begin : g_bad_cfg
      $error("pipe_carry_adder: WIDTH must be a positive multiple of SEG");
   end
   logic [NSEG:0]    rdy;
   logic [NSEG-1:0]  v_all;
   logic             sub;
   logic [WIDTH-1:0] b_in;
`ifdef PIPE_ADD_SUB_EN
   assign sub = bus.in_sub;
`else
   assign sub = 1'b0;
`endif
   assign b_in = sub ? ~bus.in_b : bus.in_b;
   // Ready ripples back from the consumer; an empty stage is always ready, so bubbles collapse.
   always_comb begin
      rdy[NSEG] = bus.out_ready;
      for (int k = NSEG - 1; k >= 0; k--)
         rdy[k] = !v_all[k] || rdy[k+1];
   end
   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      localparam int IW = WIDTH - k * SEG;
      localparam int SW = (k + 1) * SEG;
      logic [IW-1:0]  a_src, b_src;
      logic [SW-1:0]  s_src, s_d, s_q;
      logic [SEG-1:0] seg_s;
      logic           c_src, v_src, seg_c, c_d, c_q, v_d, v_q;
      if (k == 0) begin : g_head
         assign a_src = bus.in_a;
         assign b_src = b_in;
         assign c_src = sub | bus.in_cin;
         assign v_src = bus.in_valid;
         assign s_src = seg_s;
      end else begin : g_tail
         assign a_src = g_stage[k-1].g_fwd.a_q;
         assign b_src = g_stage[k-1].g_fwd.b_q;
         assign c_src = g_stage[k-1].c_q;
         assign v_src = g_stage[k-1].v_q;
         assign s_src = {seg_s, g_stage[k-1].s_q};
      end
      pipe_add_seg #(.SEG(SEG)) u_seg (
         .a   (a_src[SEG-1:0]),
         .b   (b_src[SEG-1:0]),
         .cin (c_src),
         .sum (seg_s),
         .cout(seg_c)
      );
      always_comb begin
         v_d = rdy[k] ? v_src : v_q;
         c_d = rdy[k] ? seg_c : c_q;
         s_d = rdy[k] ? s_src : s_q;
      end
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else begin
            v_q <= v_d;
            c_q <= c_d;
            s_q <= s_d;
         end
      end
      assign v_all[k] = v_q;
      // Operand segments not yet consumed travel down with the partial result.
      if (k < NSEG - 1) begin : g_fwd
         logic [IW-SEG-1:0] a_d, a_q, b_d, b_q;
         always_comb begin
            a_d = rdy[k] ? a_src[IW-1:SEG] : a_q;
            b_d = rdy[k] ? b_src[IW-1:SEG] : b_q;
         end
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end
   end
   assign bus.in_ready  = rdy[0];
   assign bus.out_valid = v_all[NSEG-1];
   assign bus.out_sum   = g_stage[NSEG-1].s_q;
   assign bus.out_cout  = g_stage[NSEG-1].c_q;
endmodule

// File: tb/tb_pipe_carry_adder.sv
// tb_pipe_carry_adder: scoreboard bench with directed, back-pressure, reset and random phases.
module tb_pipe_carry_adder;
   import pipe_add_pkg::*;
   localparam int W = 64;
   localparam int S = 8;
   localparam int N = W / S;
   typedef struct {
      logic [W:0] r;
      int         acc;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   exp_t q[$];
   int   checks = 0, failures = 0, cyc = 0, rx = 0;
   bit   lat_chk = 1'b0, rnd_on = 1'b0, or_fix = 1'b1, rnd_bit = 1'b1;
   pipe_carry_adder_if #(.WIDTH(W)) bus ();
   pipe_carry_adder #(.WIDTH(W), .SEG(S)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);
   assign bus.out_ready = rnd_on ? rnd_bit : or_fix;
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask
   function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic cin, sub);
      logic [W:0] r;
      if (sub) return {a >= b, a - b};
      r = {1'b0, a};
      r = r + {1'b0, b} + {{W{1'b0}}, cin};
      return r;
   endfunction
   task automatic send(input logic [W-1:0] a, b, input logic cin, sub);
      int n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
`ifdef PIPE_ADD_SUB_EN
      bus.in_sub   = sub;
`endif
      #1;
      while (!bus.in_ready && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (bus.in_ready) q.push_back('{model(a, b, cin, sub), cyc + 1});
      else begin
         chk("accept_timeout", 0, 1);
         bus.in_valid = 1'b0;
      end
   endtask
   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk("drain_empty", q.size(), 0);
   endtask
   // Latency counts the transfer edge itself, so a result visible right after it is latency 1.
   always @(negedge clk) begin
      #1;
      if (rst_n && bus.out_valid) begin
         if (q.size() == 0) chk("stray_out_valid", 1, 0);
         else begin
            chk("sum", bus.out_sum, q[0].r[W-1:0]);
            chk("cout", bus.out_cout, q[0].r[W]);
            if (bus.out_ready) begin
               if (lat_chk) chk("latency", cyc - q[0].acc + 1, N);
               void'(q.pop_front());
               rx++;
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n0;
      logic [W-1:0] ra, rb;
      logic         rs;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.in_cin   = 1'b0;
`ifdef PIPE_ADD_SUB_EN
      bus.in_sub   = 1'b0;
`endif
      #1 rst_n = 1'b0;
      #2;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_sum", bus.out_sum, 0);
      chk("rst_out_cout", bus.out_cout, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      lat_chk = 1'b1;
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      send(64'h0000_0000_0000_00FF, 64'd0, 1'b1, 1'b0);
      send(64'd1, 64'd2, 1'b0, 1'b0);
      send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
      send(64'd10, 64'd20, 1'b0, 1'b0);
      idle();
      drain();
`ifdef PIPE_ADD_SUB_EN
      send(64'd5, 64'd7, 1'b0, 1'b1);
      send(64'd7, 64'd5, 1'b1, 1'b1);
      send(64'd7, 64'd5, 1'b1, 1'b0);
      idle();
      drain();
`endif
      lat_chk = 1'b0;
      or_fix  = 1'b0;
      for (int i = 0; i < N; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         #1 chk("bp_in_ready", bus.in_ready, 0);
      end
      n0 = rx;
      @(negedge clk);
      or_fix = 1'b1;
      #1 chk("refill_in_ready", bus.in_ready, 1);
      drain();
      chk("bp_count", rx - n0, N);
      lat_chk = 1'b1;
      for (int i = 0; i < 4; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_in_ready", bus.in_ready, 1);
      q.delete();
      @(negedge clk);
      chk("midrst_out_sum", bus.out_sum, 0);
      chk("midrst_out_cout", bus.out_cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (N + 4) @(negedge clk);
      send(64'd123, 64'd456, 1'b1, 1'b0);
      idle();
      drain();
      rnd_on  = 1'b1;
      lat_chk = 1'b0;
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 3) == 0) idle();
         ra = {$urandom, $urandom};
         rb = ($urandom_range(0, 3) == 0) ? ~ra : {$urandom, $urandom};
`ifdef PIPE_ADD_SUB_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         send(ra, rb, 1'($urandom_range(0, 1)), rs);
      end
      idle();
      rnd_on = 1'b0;
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
